// File: rtl/string_led_multi_serializer.sv
// Multi-channel WS2812-class LED string driver: per-channel pixel FIFO + IDLE/BIT/GAP serializer.
// Optional macro SLC_INVERT_EN adds cfg_invert to flip each channel's output polarity.
module string_led_multi_serializer #(
    parameter int NUM_CH     = 4,
    parameter int PIXEL_BITS = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      cfg_t0h,
    input  logic [CNT_W-1:0]      cfg_t1h,
    input  logic [CNT_W-1:0]      cfg_tbit,
    input  logic [CNT_W-1:0]      cfg_treset,
`ifdef SLC_INVERT_EN
    input  logic [NUM_CH-1:0]     cfg_invert,
`endif
    input  logic                  px_valid,
    output logic                  px_ready,
    input  logic [CH_W-1:0]       px_ch,
    input  logic [PIXEL_BITS-1:0] px_data,
    input  logic                  px_last,
    input  logic [NUM_CH-1:0]     underrun_clr,
    output logic [NUM_CH-1:0]     led_o,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     underrun
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BCW = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BIT, S_GAP} state_t;

    logic [CNT_W-1:0]  w_tbit, w_t0h, w_t1h, w_treset;
    logic [NUM_CH-1:0] w_full;
    logic              w_ch_ok;

    // Sanitised timing; each channel latches a copy when a frame starts.
    always_comb begin
        w_tbit   = (cfg_tbit < CNT_W'(2)) ? CNT_W'(2) : cfg_tbit;
        w_t0h    = (cfg_t0h == '0) ? CNT_W'(1) :
                   (cfg_t0h > w_tbit - CNT_W'(1)) ? w_tbit - CNT_W'(1) : cfg_t0h;
        w_t1h    = (cfg_t1h == '0) ? CNT_W'(1) :
                   (cfg_t1h > w_tbit - CNT_W'(1)) ? w_tbit - CNT_W'(1) : cfg_t1h;
        w_treset = (cfg_treset == '0) ? CNT_W'(1) : cfg_treset;
    end

    assign w_ch_ok  = (int'(px_ch) < NUM_CH);
    assign px_ready = w_ch_ok ? ~w_full[px_ch] : 1'b1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [PIXEL_BITS:0]   r_mem [FIFO_DEPTH];
        logic [AW:0]           r_wp, r_rp;
        state_t                r_state;
        logic [PIXEL_BITS-1:0] r_shift;
        logic                  r_last, r_led, r_und;
        logic [BCW-1:0]        r_bcnt;
        logic [CNT_W-1:0]      r_cnt, r_tbit, r_t0h, r_t1h, r_treset;
        logic                  w_empty, w_push, w_pop, w_bit_end, w_px_end, w_line, w_und_set;
        logic [PIXEL_BITS:0]   w_head;

        assign w_empty   = (r_wp == r_rp);
        assign w_full[g] = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
        assign w_push    = px_valid && w_ch_ok && (int'(px_ch) == g) && !w_full[g];
        assign w_head    = r_mem[r_rp[AW-1:0]];
        assign w_bit_end = (r_state == S_BIT) && (r_cnt == r_tbit - CNT_W'(1));
        assign w_px_end  = w_bit_end && (r_bcnt == '0) && !r_last;
        // A non-last pixel chains straight into the next one when data is waiting.
        assign w_pop     = ((r_state == S_IDLE) && enable && !w_empty) || (w_px_end && !w_empty);
        assign w_und_set = w_px_end && w_empty;
        assign w_line    = (r_state == S_BIT) &&
                           (r_cnt < (r_shift[PIXEL_BITS-1] ? r_t1h : r_t0h));

        assign busy[g]     = (r_state != S_IDLE) || !w_empty;
        assign underrun[g] = r_und;
        assign led_o[g]    = r_led;

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wp[AW-1:0]] <= {px_last, px_data};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state  <= S_IDLE;
                r_wp     <= '0;
                r_rp     <= '0;
                r_shift  <= '0;
                r_last   <= 1'b0;
                r_bcnt   <= '0;
                r_cnt    <= '0;
                r_tbit   <= CNT_W'(2);
                r_t0h    <= CNT_W'(1);
                r_t1h    <= CNT_W'(1);
                r_treset <= CNT_W'(1);
                r_led    <= 1'b0;
                r_und    <= 1'b0;
            end else begin
                if (w_push) r_wp <= r_wp + (AW+1)'(1);
                if (w_pop) begin
                    r_rp    <= r_rp + (AW+1)'(1);
                    r_shift <= w_head[PIXEL_BITS-1:0];
                    r_last  <= w_head[PIXEL_BITS];
                    r_bcnt  <= BCW'(PIXEL_BITS-1);
                end
                r_und <= (r_und & ~underrun_clr[g]) | w_und_set;
`ifdef SLC_INVERT_EN
                r_led <= w_line ^ cfg_invert[g];
`else
                r_led <= w_line;
`endif
                case (r_state)
                    S_IDLE: if (w_pop) begin
                        r_state  <= S_BIT;
                        r_cnt    <= '0;
                        r_tbit   <= w_tbit;
                        r_t0h    <= w_t0h;
                        r_t1h    <= w_t1h;
                        r_treset <= w_treset;
                    end
                    S_BIT: if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bcnt != '0) begin
                            r_shift <= r_shift << 1;
                            r_bcnt  <= r_bcnt - BCW'(1);
                        end else if (!w_pop) begin
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    S_GAP: if (r_cnt == r_treset - CNT_W'(1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_string_led_multi_serializer.sv
// Self-checking bench: expected LED waveforms are generated from pixel bits and sanitised timing.
module tb_string_led_multi_serializer;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        enable = 1;
    logic [15:0] cfg_t0h = 2, cfg_t1h = 5, cfg_tbit = 8, cfg_treset = 20;
    logic        px_valid = 0;
    logic        px_ready;
    logic [1:0]  px_ch = 0;
    logic [23:0] px_data = 0;
    logic        px_last = 0;
    logic [3:0]  underrun_clr = 0;
    logic [3:0]  led_o, busy, underrun;

    int total = 0;
    int bad = 0;

    typedef struct { int t0h, t1h, tbit, trst, h0, h1, per, tr; } vec_t;
    vec_t tbl[6];
    logic [23:0] pq[4][$];
    logic [23:0] q8[$];

    string_led_multi_serializer dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_t0h(cfg_t0h), .cfg_t1h(cfg_t1h), .cfg_tbit(cfg_tbit), .cfg_treset(cfg_treset),
        .px_valid(px_valid), .px_ready(px_ready), .px_ch(px_ch), .px_data(px_data),
        .px_last(px_last), .underrun_clr(underrun_clr),
        .led_o(led_o), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic push(input int ch, input logic [23:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        px_valid = 1; px_ch = 2'(ch); px_data = d; px_last = l;
        #1;
        while (!px_ready && n < 3000) begin @(negedge clk); #1; n++; end
        if (!px_ready) chk("push_ready_timeout", 0, 1);
        @(posedge clk);
        #1 px_valid = 0;
    endtask

    // Waits for the first high sample, then compares every cycle of every bit, the latch gap
    // length (busy drops on the last gap sample) and the final underrun flag.
    task automatic check_frame(input int ch, input logic [23:0] px[$], input int h0, input int h1,
                               input int per, input int tr, input int exp_und, input string nm);
        int n = 0;
        int errs = 0;
        int gerr = 0;
        while (led_o[ch] !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        chk({nm, "_rise"}, int'(led_o[ch]), 1);
        foreach (px[p]) begin
            for (int b = 23; b >= 0; b--) begin
                for (int c = 0; c < per; c++) begin
                    if (int'(led_o[ch]) != ((c < (px[p][b] ? h1 : h0)) ? 1 : 0)) errs++;
                    @(negedge clk);
                end
            end
        end
        chk({nm, "_wave"}, errs, 0);
        for (int i = 0; i < tr; i++) begin
            if (led_o[ch] !== 1'b0) gerr++;
            if (int'(busy[ch]) != ((i < tr - 1) ? 1 : 0)) gerr++;
            @(negedge clk);
        end
        chk({nm, "_gap"}, gerr, 0);
        chk({nm, "_und"}, int'(underrun[ch]), exp_und);
    endtask

    task automatic set_cfg(input int t0, input int t1, input int tb, input int trs);
        @(negedge clk);
        cfg_t0h = 16'(t0); cfg_t1h = 16'(t1); cfg_tbit = 16'(tb); cfg_treset = 16'(trs);
    endtask

    initial begin
        logic [23:0] one[$];
        logic [23:0] two[$];
        int t0, t1, tb, trs, tbe, h0, h1, tre, n;

        tbl[0] = '{2, 5, 8, 20, 2, 5, 8, 20};
        tbl[1] = '{2, 10, 8, 5, 2, 7, 8, 5};
        tbl[2] = '{0, 0, 0, 0, 1, 1, 2, 1};
        tbl[3] = '{0, 5, 1, 3, 1, 1, 2, 3};
        tbl[4] = '{3, 3, 3, 2, 2, 2, 3, 2};
        tbl[5] = '{9, 1, 4, 1, 3, 1, 4, 1};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_led", int'(led_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_und", int'(underrun), 0);
        chk("rst_ready", int'(px_ready), 1);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // single last pixel: 2-cycle rise latency then full waveform
        push(0, 24'hA50000, 1'b1);
        @(negedge clk); chk("lat_e0", int'(led_o[0]), 0);
        @(negedge clk); chk("lat_e1", int'(led_o[0]), 0);
        @(negedge clk); chk("lat_e2", int'(led_o[0]), 1);
        one = '{24'hA50000};
        check_frame(0, one, 2, 5, 8, 20, 0, "t1");

        // two pixels back-to-back, contiguous bits
        two = '{24'h123456, 24'hFEDCBA};
        fork
            check_frame(1, two, 2, 5, 8, 20, 0, "t2");
            begin push(1, two[0], 1'b0); push(1, two[1], 1'b1); end
        join

        // enable low holds a full FIFO; other channels keep accepting
        @(negedge clk); enable = 0;
        for (int i = 0; i < 8; i++) begin
            q8.push_back(24'($urandom));
            push(2, q8[i], i == 7);
        end
        repeat (20) @(negedge clk);
        px_ch = 2; #1; chk("t3_ready_full", int'(px_ready), 0);
        px_ch = 3; #1; chk("t3_ready_other", int'(px_ready), 1);
        chk("t3_led_held", int'(led_o[2]), 0);
        chk("t3_busy", int'(busy[2]), 1);
        fork
            check_frame(2, q8, 2, 5, 8, 20, 0, "t3");
            begin @(negedge clk); enable = 1; end
        join

        // underrun: non-last pixel with nothing behind it; sticky until cleared
        push(0, 24'h0F0F0F, 1'b0);
        one = '{24'h0F0F0F};
        check_frame(0, one, 2, 5, 8, 20, 1, "t4");
        repeat (40) @(negedge clk);
        chk("t4_hold", int'(underrun[0]), 1);
        underrun_clr = 4'b0001;
        @(negedge clk); underrun_clr = 0;
        chk("t4_clr", int'(underrun[0]), 0);

        // timing sanitise table
        foreach (tbl[k]) begin
            set_cfg(tbl[k].t0h, tbl[k].t1h, tbl[k].tbit, tbl[k].trst);
            push(3, 24'hA50000, 1'b1);
            one = '{24'hA50000};
            check_frame(3, one, tbl[k].h0, tbl[k].h1, tbl[k].per, tbl[k].tr, 0,
                        $sformatf("tbl%0d", k));
        end

        // randomized frames on all channels at once
        for (int r = 0; r < 5; r++) begin
            t0 = $urandom_range(0, 7); t1 = $urandom_range(0, 7);
            tb = $urandom_range(0, 6); trs = $urandom_range(0, 6);
            tbe = (tb < 2) ? 2 : tb;
            h0 = (t0 < 1) ? 1 : ((t0 > tbe - 1) ? tbe - 1 : t0);
            h1 = (t1 < 1) ? 1 : ((t1 > tbe - 1) ? tbe - 1 : t1);
            tre = (trs < 1) ? 1 : trs;
            set_cfg(t0, t1, tb, trs);
            for (int c = 0; c < 4; c++) begin
                pq[c].delete();
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) pq[c].push_back(24'($urandom));
            end
            fork
                begin
                    for (int j = 0; j < 3; j++)
                        for (int c = 0; c < 4; c++)
                            if (j < pq[c].size()) push(c, pq[c][j], j == pq[c].size() - 1);
                end
            join_none
            for (int c = 0; c < 4; c++) begin
                automatic int cc = c;
                fork
                    check_frame(cc, pq[cc], h0, h1, tbe, tre, 0, $sformatf("rnd%0d_ch%0d", r, cc));
                join_none
            end
            wait fork;
        end

        // asynchronous reset mid-bit clears outputs, FIFOs and sticky flags
        set_cfg(1, 1, 2, 1);
        push(1, 24'h000001, 1'b0);
        repeat (70) @(negedge clk);
        chk("t6_und_pre", int'(underrun[1]), 1);
        set_cfg(2, 5, 8, 20);
        push(0, 24'hFFFFFF, 1'b1);
        push(2, 24'h111111, 1'b0);
        push(2, 24'h222222, 1'b1);
        n = 0;
        while (led_o[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("t6_led_pre", int'(led_o[0]), 1);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("t6_led", int'(led_o), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_und", int'(underrun), 0);
        @(negedge clk); rst_n = 1;
        repeat (30) @(negedge clk);
        chk("t6_busy_after", int'(busy), 0);
        chk("t6_led_after", int'(led_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
